// File: rtl/uart_rx_framer_if.sv
// Byte-stream handshake between the UART receive framer and its consumer.
// The master side presents received bytes and error pulses; the slave side returns ready.
interface uart_rx_framer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (output data, output valid, output frame_err, output overrun, input ready);
  modport slave  (input data, input valid, input frame_err, input overrun, output ready);
endinterface

// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: synchronises the serial pin, majority-votes each bit at
// mid-period and hands whole bytes to the consumer through a one-entry holding register.
module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  uart_rx_framer_if.master  bus
);

  localparam int unsigned HALF   = CLKS_PER_BIT / 2;
  localparam logic [15:0] SAMP0  = 16'(HALF - 1);
  localparam logic [15:0] SAMP1  = 16'(HALF);
  localparam logic [15:0] COMMIT = 16'(HALF + 1);
  localparam logic [15:0] LAST   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic        rx_meta_r, rx_sync_r, rx_hist_r;
  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [2:0]  idx_r, idx_nxt_s;
  logic [7:0]  shreg_r, shreg_nxt_s;
  logic [1:0]  samp_r, samp_nxt_s;
  logic        deliver_s, ferr_s, maj_s, commit_s, last_s;
  logic [7:0]  data_r;
  logic        valid_r, ferr_r, ovr_r;

  assign maj_s    = majority3(samp_r[0], samp_r[1], rx_sync_r);
  assign commit_s = (cnt_r == COMMIT);
  assign last_s   = (cnt_r == LAST);

  // Pin synchroniser plus one history stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_hist_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_hist_r <= rx_sync_r;
    end
  end

  // Framer state, bit timer, bit index, shift register and early samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
      samp_r  <= 2'b11;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shreg_r <= shreg_nxt_s;
      samp_r  <= samp_nxt_s;
    end
  end

  // Next-state logic; the third vote is the live synchronised pin at the commit count.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + 16'd1;
    idx_nxt_s   = idx_r;
    shreg_nxt_s = shreg_r;
    samp_nxt_s  = samp_r;
    deliver_s   = 1'b0;
    ferr_s      = 1'b0;

    if (cnt_r == SAMP0) begin
      samp_nxt_s[0] = rx_sync_r;
    end else if (cnt_r == SAMP1) begin
      samp_nxt_s[1] = rx_sync_r;
    end else begin
      samp_nxt_s = samp_r;
    end

    case (state_r)
      IDLE: begin
        cnt_nxt_s = 16'd0;
        if (rx_hist_r && !rx_sync_r) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (commit_s && maj_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 16'd0;
        end else if (last_s) begin
          state_nxt_s = DATA;
          cnt_nxt_s   = 16'd0;
          idx_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (commit_s) begin
          shreg_nxt_s = {maj_s, shreg_r[7:1]};
        end else begin
          shreg_nxt_s = shreg_r;
        end
        if (last_s) begin
          cnt_nxt_s = 16'd0;
          if (idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (commit_s) begin
          cnt_nxt_s = 16'd0;
          if (maj_s) begin
            deliver_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            ferr_s      = 1'b1;
            state_nxt_s = BRK;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      BRK: begin
        cnt_nxt_s = 16'd0;
        if (rx_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BRK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 16'd0;
      end
    endcase
  end

  // Holding register: a same-cycle delivery and consumption replaces the byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ferr_r <= ferr_s;
      ovr_r  <= deliver_s && valid_r && !bus.ready;
      if (deliver_s && (!valid_r || bus.ready)) begin
        data_r  <= shreg_r;
        valid_r <= 1'b1;
      end else if (valid_r && bus.ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = ferr_r;
  assign bus.overrun   = ovr_r;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: one instance at the default divisor and one at
// the minimum divisor of 8, each driven by its own serial line and reset.
module tb_uart_rx_framer;

  localparam int CA    = 217;
  localparam int CB    = 8;
  localparam int LAT_A = 3 + 9 * CA + (CA / 2) + 2;

  logic clk = 1'b0;
  logic rst_a, rst_b, rx_a, rx_b;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   t0_a;

  int   rise_cnt_a = 0, rise_cyc_a = 0, vhigh_a = 0, ferr_cnt_a = 0, ferr_cyc_a = 0;
  int   ovr_cnt_a = 0, ovr_cyc_a = 0;
  logic vprev_a = 1'b0;
  logic [7:0] acc_a[$];
  int   rise_cnt_b = 0, ferr_cnt_b = 0, ovr_cnt_b = 0;
  logic vprev_b = 1'b0;
  logic [7:0] acc_b[$];

  uart_rx_framer_if bus_a();
  uart_rx_framer_if bus_b();

  uart_rx_framer #(.CLKS_PER_BIT(CA)) dut_a (.clk(clk), .reset(rst_a), .uart_rx(rx_a), .bus(bus_a));
  uart_rx_framer #(.CLKS_PER_BIT(CB)) dut_b (.clk(clk), .reset(rst_b), .uart_rx(rx_b), .bus(bus_b));

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled just after the falling edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    #1;
    if (bus_a.valid && bus_a.ready) acc_a.push_back(bus_a.data);
    if (bus_a.valid) vhigh_a <= vhigh_a + 1;
    if (bus_a.valid && !vprev_a) begin
      rise_cnt_a <= rise_cnt_a + 1;
      rise_cyc_a <= cyc;
    end
    vprev_a <= bus_a.valid;
    if (bus_a.frame_err) begin
      ferr_cnt_a <= ferr_cnt_a + 1;
      ferr_cyc_a <= cyc;
    end
    if (bus_a.overrun) begin
      ovr_cnt_a <= ovr_cnt_a + 1;
      ovr_cyc_a <= cyc;
    end
    if (bus_b.valid && bus_b.ready) acc_b.push_back(bus_b.data);
    if (bus_b.valid && !vprev_b) rise_cnt_b <= rise_cnt_b + 1;
    vprev_b <= bus_b.valid;
    if (bus_b.frame_err) ferr_cnt_b <= ferr_cnt_b + 1;
    if (bus_b.overrun) ovr_cnt_b <= ovr_cnt_b + 1;
  end

  // Caller is at a falling edge; the start bit is driven immediately so frames can abut.
  task automatic send_a(input logic [7:0] b, input logic stop, input int hold);
    t0_a = cyc;
    rx_a = 1'b0;
    repeat (CA) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = b[i];
      repeat (CA) @(negedge clk);
    end
    rx_a = stop;
    repeat (CA) @(negedge clk);
    if (!stop) begin
      repeat (hold) @(negedge clk);
      rx_a = 1'b1;
      repeat (CA) @(negedge clk);
    end
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_b = 1'b0;
    repeat (CB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_b = b[i];
      repeat (CB) @(negedge clk);
    end
    rx_b = 1'b1;
    repeat (CB) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    bus_a.ready = 1'b1; bus_b.ready = 1'b1;
    repeat (4) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (bus_a.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_a.valid); else n_pass++;
    n_chk++; if (bus_a.data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus_a.data); else n_pass++;
    n_chk++; if (bus_a.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", bus_a.frame_err); else n_pass++;
    n_chk++; if (bus_a.overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", bus_a.overrun); else n_pass++;
    n_chk++; if (bus_b.valid !== 1'b0) $display("FAIL reset_valid_b: got %b want 0", bus_b.valid); else n_pass++;
  endtask

  task automatic test_single;
    int r0, v0, f0, o0, q0;
    r0 = rise_cnt_a; v0 = vhigh_a; f0 = ferr_cnt_a; o0 = ovr_cnt_a; q0 = acc_a.size();
    send_a(8'hA5, 1'b1, 0);
    repeat (10) @(negedge clk);
    n_chk++; if (rise_cnt_a - r0 !== 1) $display("FAIL single_rise: got %0d want 1", rise_cnt_a - r0); else n_pass++;
    n_chk++; if (rise_cyc_a - t0_a !== LAT_A) $display("FAIL single_latency: got %0d want %0d", rise_cyc_a - t0_a, LAT_A); else n_pass++;
    n_chk++; if (vhigh_a - v0 !== 1) $display("FAIL single_width: got %0d want 1", vhigh_a - v0); else n_pass++;
    n_chk++; if (acc_a.size() - q0 !== 1 || acc_a[acc_a.size()-1] !== 8'hA5) $display("FAIL single_data: got %h want a5", acc_a[acc_a.size()-1]); else n_pass++;
    n_chk++; if ((ferr_cnt_a - f0) + (ovr_cnt_a - o0) !== 0) $display("FAIL single_errs: got %0d want 0", (ferr_cnt_a - f0) + (ovr_cnt_a - o0)); else n_pass++;
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = rise_cnt_a; f0 = ferr_cnt_a;
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CA) @(negedge clk);
    n_chk++; if (rise_cnt_a !== r0) $display("FAIL glitch_novalid: got %0d want %0d", rise_cnt_a, r0); else n_pass++;
    n_chk++; if (ferr_cnt_a !== f0) $display("FAIL glitch_noferr: got %0d want %0d", ferr_cnt_a, f0); else n_pass++;
    send_a(8'h5A, 1'b1, 0);
    repeat (10) @(negedge clk);
    n_chk++; if (rise_cyc_a - t0_a !== LAT_A) $display("FAIL glitch_idle_latency: got %0d want %0d", rise_cyc_a - t0_a, LAT_A); else n_pass++;
    n_chk++; if (acc_a[acc_a.size()-1] !== 8'h5A) $display("FAIL glitch_next_data: got %h want 5a", acc_a[acc_a.size()-1]); else n_pass++;
  endtask

  task automatic test_frame_err;
    int r0, f0, q0;
    r0 = rise_cnt_a; f0 = ferr_cnt_a; q0 = acc_a.size();
    send_a(8'h3C, 1'b0, 500);
    n_chk++; if (ferr_cnt_a - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt_a - f0); else n_pass++;
    n_chk++; if (ferr_cyc_a - t0_a !== LAT_A) $display("FAIL ferr_timing: got %0d want %0d", ferr_cyc_a - t0_a, LAT_A); else n_pass++;
    n_chk++; if (rise_cnt_a !== r0 || acc_a.size() !== q0) $display("FAIL ferr_nobyte: got %0d want %0d", rise_cnt_a, r0); else n_pass++;
    send_a(8'h81, 1'b1, 0);
    repeat (10) @(negedge clk);
    n_chk++; if (acc_a.size() - q0 !== 1 || acc_a[acc_a.size()-1] !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", acc_a[acc_a.size()-1]); else n_pass++;
    n_chk++; if (ferr_cnt_a - f0 !== 1) $display("FAIL ferr_after_next: got %0d want 1", ferr_cnt_a - f0); else n_pass++;
  endtask

  task automatic test_overrun;
    int o0;
    int t22;
    o0 = ovr_cnt_a;
    bus_a.ready = 1'b0;
    send_a(8'h11, 1'b1, 0);
    send_a(8'h22, 1'b1, 0);
    t22 = t0_a;
    repeat (10) @(negedge clk);
    n_chk++; if (bus_a.data !== 8'h11) $display("FAIL ovr_hold_data: got %h want 11", bus_a.data); else n_pass++;
    n_chk++; if (bus_a.valid !== 1'b1) $display("FAIL ovr_hold_valid: got %b want 1", bus_a.valid); else n_pass++;
    n_chk++; if (ovr_cnt_a - o0 !== 1) $display("FAIL ovr_count: got %0d want 1", ovr_cnt_a - o0); else n_pass++;
    n_chk++; if (ovr_cyc_a - t22 !== LAT_A) $display("FAIL ovr_timing: got %0d want %0d", ovr_cyc_a - t22, LAT_A); else n_pass++;
    bus_a.ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus_a.valid !== 1'b0) $display("FAIL ovr_consume_valid: got %b want 0", bus_a.valid); else n_pass++;
    n_chk++; if (acc_a[acc_a.size()-1] !== 8'h11) $display("FAIL ovr_consume_data: got %h want 11", acc_a[acc_a.size()-1]); else n_pass++;
  endtask

  task automatic test_replace;
    int o0;
    bus_a.ready = 1'b0;
    send_a(8'h55, 1'b1, 0);
    n_chk++; if (bus_a.valid !== 1'b1 || bus_a.data !== 8'h55) $display("FAIL replace_hold: got %b/%h want 1/55", bus_a.valid, bus_a.data); else n_pass++;
    o0 = ovr_cnt_a;
    fork
      send_a(8'h66, 1'b1, 0);
      begin
        repeat (LAT_A - 1) @(negedge clk);
        bus_a.ready = 1'b1;
        @(negedge clk);
        bus_a.ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    n_chk++; if (bus_a.valid !== 1'b1) $display("FAIL replace_valid: got %b want 1", bus_a.valid); else n_pass++;
    n_chk++; if (bus_a.data !== 8'h66) $display("FAIL replace_data: got %h want 66", bus_a.data); else n_pass++;
    n_chk++; if (ovr_cnt_a !== o0) $display("FAIL replace_noovr: got %0d want %0d", ovr_cnt_a, o0); else n_pass++;
    bus_a.ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus_a.valid !== 1'b0) $display("FAIL replace_consume: got %b want 0", bus_a.valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int r0, q0, f0, o0;
    @(negedge clk);
    r0 = rise_cnt_b; q0 = acc_b.size();
    fork
      send_b(8'hFF);
      begin
        repeat (5 * CB + 4) @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
      end
    join
    repeat (4 * CB) @(negedge clk);
    n_chk++; if (rise_cnt_b !== r0 || acc_b.size() !== q0) $display("FAIL b2b_reset_nobyte: got %0d want %0d", rise_cnt_b, r0); else n_pass++;
    n_chk++; if (bus_b.valid !== 1'b0) $display("FAIL b2b_reset_valid: got %b want 0", bus_b.valid); else n_pass++;
    q0 = acc_b.size(); f0 = ferr_cnt_b; o0 = ovr_cnt_b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_b(b);
    end
    repeat (3 * CB) @(negedge clk);
    n_chk++; if (acc_b.size() - q0 !== 16) $display("FAIL b2b_count: got %0d want 16", acc_b.size() - q0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (q0 + i >= acc_b.size()) $display("FAIL b2b_missing[%0d]: got none want %h", i, exp_q[i]);
      else if (acc_b[q0 + i] !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, acc_b[q0 + i], exp_q[i]);
      else n_pass++;
    end
    n_chk++; if ((ferr_cnt_b - f0) + (ovr_cnt_b - o0) !== 0) $display("FAIL b2b_errs: got %0d want 0", (ferr_cnt_b - f0) + (ovr_cnt_b - o0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    repeat (20) @(negedge clk);
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    repeat (20) @(negedge clk);
    test_replace();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
